// File: rtl/frq_pkg.sv
// Shared definitions for the frq_meter gated frequency counter.
//   frq_state_e : measurement FSM states (IDLE, GATE, LATCH)
//   BCD_W       : bits per BCD digit
//   BCD_MAX     : highest decimal digit value
//   gate_cnt_w  : width of the gate-window cycle counter
package frq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } frq_state_e;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int gate_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frq_meter_bcd_digit_cnt.sv
// One decade (0..9) counter of the frq_meter BCD result cascade.
// Ports:
//   mclk      : system clock
//   rst       : asynchronous active-low reset
//   clr       : synchronous clear to 0 (wins over inc_in)
//   inc_in    : advance by one this cycle
//   digit     : current digit value 0..9
//   carry_out : digit is 9 and being advanced (feeds next digit's inc_in)
module bcd_digit_cnt
  import frq_pkg::*;
(
  input  logic       mclk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc_in) begin
      digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) digit_q <= 4'd0;
    else      digit_q <= digit_d;
  end

  assign digit     = digit_q;
  assign carry_out = (digit_q == BCD_MAX) && inc_in;

endmodule

// File: rtl/frq_meter.sv
// Gated frequency counter. Counts rising edges of the asynchronous sig_in
// over a window of GATE_CYCLES mclk cycles and presents the count as packed
// BCD (digit 0 in the LSBs), saturating at all-9s with a sticky overflow.
// Single-shot (start) or continuous (cont) measurement.
//
// Handshake: valid is a one-cycle pulse in the cycle that bcd/overflow first
// show a new result; there is no back-pressure. start is a one-cycle request
// honoured only in IDLE; in LATCH, cont alone decides whether to re-arm.
//
// Ports:
//   mclk      : system clock
//   rst       : asynchronous active-low reset
//   sig_in    : measured signal (asynchronous)
//   start     : begin a measurement (IDLE only)
//   cont      : continuous mode, re-arm after every gate
//   hold      : (only with FRQ_METER_HOLD_EN) freeze bcd/overflow, mute valid
//   busy      : gate window open
//   valid     : new result pulse
//   bcd       : result, 4*DIGITS bits
//   overflow  : result saturated
//   dbg_state : current FSM state (frq_state_e encoding)
//
// Optional feature macro: FRQ_METER_HOLD_EN.
module frq_meter
  import frq_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  sig_in,
  input  logic                  start,
  input  logic                  cont,
`ifdef FRQ_METER_HOLD_EN
  input  logic                  hold,
`endif
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int            GW        = gate_cnt_w(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  // ---------------------------------------------------------------- input path
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_pulse;

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

  // ---------------------------------------------------------------------- FSM
  frq_state_e state_q, state_d;
  logic [GW-1:0] gate_q, gate_d;
  logic gate_c, latch_c, clr_c, latch_upd_c;
  logic hold_c;

`ifdef FRQ_METER_HOLD_EN
  assign hold_c = hold;
`else
  assign hold_c = 1'b0;
`endif

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = GATE;
      GATE:    if (gate_q == GATE_LAST) state_d = LATCH;
      LATCH:   state_d = cont ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gate_c      = (state_q == GATE);
    latch_c     = (state_q == LATCH);
    // Every entry into GATE starts from a cleared measurement.
    clr_c       = ((state_q == IDLE) && start) || (latch_c && cont);
    latch_upd_c = latch_c && !hold_c;
  end

  assign dbg_state = state_q;
  assign busy      = gate_c;

  // ------------------------------------------------------------- gate counter
  always_comb begin
    gate_d = gate_q;
    if (clr_c) begin
      gate_d = '0;
    end else if (gate_c) begin
      gate_d = (gate_q == GATE_LAST) ? '0 : gate_q + GW'(1);
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) gate_q <= '0;
    else      gate_q <= gate_d;
  end

  // ------------------------------------------------------------ BCD cascade
  logic [4*DIGITS-1:0] cnt_digits;
  logic [DIGITS-1:0]   inc_chain;
  logic [DIGITS-1:0]   carry;
  logic [DIGITS-1:0]   nines;
  logic                sat, edge_in_gate;
  logic                unused_top_carry;

  // Saturation: at all-9s the cascade is not advanced, so it never wraps.
  assign sat          = &nines;
  assign edge_in_gate = edge_pulse & gate_c;
  assign inc_chain[0] = edge_in_gate & ~sat;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cnt u_digit (
      .mclk      (mclk),
      .rst       (rst),
      .clr       (clr_c),
      .inc_in    (inc_chain[i]),
      .digit     (cnt_digits[BCD_W*i +: BCD_W]),
      .carry_out (carry[i])
    );
    assign nines[i] = (cnt_digits[BCD_W*i +: BCD_W] == BCD_MAX);
    if (i < DIGITS - 1) begin : g_chain
      assign inc_chain[i+1] = carry[i];
    end
  end

  // The top digit's carry can never fire because the cascade stops at all-9s.
  assign unused_top_carry = carry[DIGITS-1];

  // Sticky overflow for the measurement in progress.
  logic ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_c)                   ovf_cnt_d = 1'b0;
    else if (edge_in_gate & sat) ovf_cnt_d = 1'b1;
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) ovf_cnt_q <= 1'b0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end

  // ------------------------------------------------------------ result latch
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  always_comb begin
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    valid_d = latch_upd_c;
    if (latch_upd_c) begin
      bcd_d = cnt_digits;
      ovf_d = ovf_cnt_q;
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_frq_meter.sv
// Self-checking bench for frq_meter. Two instances: dut (GATE_CYCLES=100,
// DIGITS=4) and dut2 (GATE_CYCLES=1000, DIGITS=2) share clock, reset and
// sig_in. Expected results are pushed into per-instance queues when a
// measurement is started; monitors pop and compare on every valid pulse.
module tb_frq_meter;
  import frq_pkg::*;

  // ---------------------------------------------------------- clock / reset
  logic mclk = 1'b0;
  logic rst  = 1'b0;
  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // ------------------------------------------------------------- DUT wiring
  logic        sig_in = 1'b0;
  logic        start = 1'b0, cont = 1'b0;
  logic        start2 = 1'b0;
  logic        cont2 = 1'b0;
  logic        busy, valid, overflow;
  logic [15:0] bcd;
  logic [1:0]  dbg_state;
  logic        busy2, valid2, overflow2;
  logic [7:0]  bcd2;
  logic [1:0]  dbg_state2;

  frq_meter #(.GATE_CYCLES(100), .DIGITS(4), .SYNC_STAGES(2)) dut (
    .mclk(mclk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
`ifdef FRQ_METER_HOLD_EN
    .hold(1'b0),
`endif
    .busy(busy), .valid(valid), .bcd(bcd), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  frq_meter #(.GATE_CYCLES(1000), .DIGITS(2), .SYNC_STAGES(2)) dut2 (
    .mclk(mclk), .rst(rst), .sig_in(sig_in), .start(start2), .cont(cont2),
`ifdef FRQ_METER_HOLD_EN
    .hold(1'b0),
`endif
    .busy(busy2), .valid(valid2), .bcd(bcd2), .overflow(overflow2),
    .dbg_state(dbg_state2)
  );

  // ----------------------------------------------------- sig_in generator
  int   sig_period = 0;   // 0: drive sig_const
  logic sig_const  = 1'b0;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge mclk);
      #1;
      if (sig_period > 0) begin
        ph     = (ph + 1) % sig_period;
        sig_in = (ph < sig_period / 2);
      end else begin
        sig_in = sig_const;
      end
    end
  end

  // ------------------------------------------------------------ scoreboard
  int tests  = 0;
  int errors = 0;

  logic [16:0] exp_q[$];   // {overflow, bcd} for dut
  logic        alt_q[$];   // 1: exp or exp+1 accepted (phase-dependent)
  logic [8:0]  exp2_q[$];  // {overflow, bcd} for dut2

  int per_epoch = 0;       // bumped by main when period checking starts
  logic per_chk = 1'b0;
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for dut: result value and continuous-mode spacing.
  initial begin
    int last_v, last_ep;
    logic [16:0] e, got;
    logic a;
    last_v  = 0;
    last_ep = -1;
    forever begin
      @(negedge mclk);
      if (busy) busy_cnt++;
      if (valid) begin
        got = {overflow, bcd};
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {15'd0, got}, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          a = alt_q.pop_front();
          if (a && got == e + 17'd1) chk("result_alt", {15'd0, got}, {15'd0, e + 17'd1});
          else                       chk("result", {15'd0, got}, {15'd0, e});
        end
        if (per_chk && last_ep == per_epoch) chk("cont_period", cyc - last_v, 101);
        last_v  = cyc;
        last_ep = per_chk ? per_epoch : -1;
      end
    end
  end

  // Monitor for dut2.
  initial begin
    logic [8:0] e2;
    forever begin
      @(negedge mclk);
      if (valid2) begin
        if (exp2_q.size() == 0) begin
          chk("unexpected_valid2", {23'd0, overflow2, bcd2}, 32'hDEAD);
        end else begin
          e2 = exp2_q.pop_front();
          chk("result2", {23'd0, overflow2, bcd2}, {23'd0, e2});
        end
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge mclk); #1 start = 1'b1;
    @(posedge mclk); #1 start = 1'b0;
  endtask

  task automatic push(input logic [16:0] e, input logic a);
    exp_q.push_back(e);
    alt_q.push_back(a);
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    int b0;

    // Reset state.
    wait_cyc(3);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_bcd", {16'd0, bcd}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    chk("rst_state2", {30'd0, dbg_state2}, {30'd0, IDLE});
    rst = 1'b1;

    // Period 10 over 100 cycles: ten edges, busy for exactly 100 cycles.
    sig_period = 10;
    wait_cyc(20);
    b0 = busy_cnt;
    push(17'h0_0010, 1'b0);
    pulse_start();
    wait_cyc(20);
    chk("gate_state", {30'd0, dbg_state}, {30'd0, GATE});
    wait_cyc(90);
    chk("single_missing", exp_q.size(), 0);
    chk("busy_len", busy_cnt - b0, 100);
    wait_cyc(30);
    chk("bcd_hold", {16'd0, bcd}, 32'h0010);
    chk("idle_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // Constant-high input: no edges.
    sig_period = 0;
    sig_const  = 1'b1;
    wait_cyc(10);
    push(17'h0_0000, 1'b0);
    pulse_start();
    wait_cyc(110);
    chk("const_missing", exp_q.size(), 0);

    // dut2: 250 edges into two digits saturates at 99 with overflow.
    sig_period = 4;
    wait_cyc(10);
    exp2_q.push_back(9'h1_99);
    @(posedge mclk); #1 start2 = 1'b1;
    @(posedge mclk); #1 start2 = 1'b0;
    wait_cyc(1010);
    chk("sat_missing", exp2_q.size(), 0);
    chk("sat_state2", {30'd0, dbg_state2}, {30'd0, IDLE});

    // Continuous mode, period 8 (12 or 13 edges per gate), drop cont in gate 4.
    sig_period = 8;
    wait_cyc(10);
    per_epoch = per_epoch + 1;
    per_chk   = 1'b1;
    for (int k = 0; k < 4; k++) push(17'h0_0012, 1'b1);
    cont = 1'b1;
    pulse_start();
    wait_cyc(3 * 101 + 50);
    chk("cont_mid_state", {30'd0, dbg_state}, {30'd0, GATE});
    cont = 1'b0;
    wait_cyc(80);
    chk("cont_missing", exp_q.size(), 0);
    chk("cont_busy_end", {31'd0, busy}, 0);
    per_chk = 1'b0;
    wait_cyc(150);

    // Second start at gate cycle 50 is ignored.
    sig_period = 10;
    wait_cyc(10);
    b0 = busy_cnt;
    push(17'h0_0010, 1'b0);
    pulse_start();
    wait_cyc(49);
    pulse_start();
    wait_cyc(60);
    chk("restart_missing", exp_q.size(), 0);
    wait_cyc(120);
    chk("restart_busy_len", busy_cnt - b0, 100);

    // Reset at gate cycle 40 aborts without a result.
    pulse_start();
    wait_cyc(40);
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_valid", {31'd0, valid}, 0);
    chk("abort_bcd", {16'd0, bcd}, 0);
    chk("abort_ovf", {31'd0, overflow}, 0);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(150);
    chk("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // Fresh measurement after the abort.
    push(17'h0_0010, 1'b0);
    pulse_start();
    wait_cyc(110);
    chk("fresh_missing", exp_q.size(), 0);
    chk("fresh_bcd", {16'd0, bcd}, 32'h0010);
    wait_cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
